colisao_placar: RTL and testbench
=================================

Name: colisao_placar

Overview:
- Downstream of the entities stage; consumes ally/enemy ball, ship and enemy-array positions once per video frame.
- Scans enemies sequentially (one comparator, one enemy per cycle) and resolves ball-vs-enemy and enemy-ball-vs-ship hits.
- Emits kill/consume pulses back to entities, and keeps score, player lives and game-over/victory state for the HUD.

Parameters:
- SIZE_ENEMY, 10, number of enemies; matches the entities array size.
- SCORE_PER_KILL, 10, points added per enemy killed.
- SCORE_W, 16, score register width.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse that starts one evaluation pass.
- pausa  in  1  pause; frame_tick is ignored while high.
- reiniciarJogo  in  1  synchronous game restart; same effect as reset.
- x_bola_aliada, y_bola_aliada, raio_bola_aliada  in  10 each  ally ball centre and radius.
- x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga  in  10 each  enemy ball centre and radius.
- x_nave, y_nave, largura_nave, altura_nave  in  10 each  ship top-left corner and size.
- x_inimigo, y_inimigo  in  10*SIZE_ENEMY each  packed enemy top-left corners; enemy i occupies bits [10i+9:10i].
- largura_inimigo, altura_inimigo  in  10 each  common enemy size.
- vidas_inimigo  in  SIZE_ENEMY  alive flag per enemy.
- acerto_inimigo  out  SIZE_ENEMY  one-hot kill pulse.
- bateu  out  1  ally ball consumed pulse.
- nave_atingida  out  1  ship hit pulse.
- vidas_jogador  out  2  remaining player lives.
- pontuacao  out  SCORE_W  score.
- fim_jogo  out  1  sticky game over.
- vitoria  out  1  sticky victory.
- busy  out  1  evaluation pass in progress.

Behaviour:
- Reset values (reset low or reiniciarJogo high): state IDLE, all pulses 0, vidas_jogador=3, pontuacao=0, fim_jogo=0, vitoria=0, busy=0.
- FSM states: IDLE, SNAP, SCAN, NAVE, UPDATE.
- IDLE->SNAP on frame_tick && !pausa && !fim_jogo && !vitoria. Otherwise frame_tick is dropped. A frame_tick while busy is also dropped.
- SNAP: latch every position/size input and vidas_inimigo; busy=1. Later input changes have no effect on the pass.
- SCAN: index k runs 0..SIZE_ENEMY-1, one enemy per cycle. Exits to NAVE after k=SIZE_ENEMY-1.
- A hit is recorded only for the first (lowest-index) alive enemy that overlaps. Later overlaps in the same pass are ignored.
- Also counts alive enemies during SCAN.
- NAVE: checks enemy ball against the ship, then goes to UPDATE.
- UPDATE: registers the outputs, returns to IDLE, busy=0.
- Pulse timing: acerto_inimigo, bateu and nave_atingida are high for exactly one cycle, SIZE_ENEMY+3 cycles after the accepted frame_tick edge.
- Overlap test: axis-aligned boxes using 11-bit unsigned arithmetic.
  - Ball box is [x-r, x+r] x [y-r, y+r], with x-r and y-r saturated at 0.
  - Rectangle is [x, x+w) x [y, y+h).
  - Overlap when ball_lo < rect_hi && ball_hi >= rect_lo on both axes.
- Kill: acerto_inimigo[k]=1, bateu=1, and pontuacao += SCORE_PER_KILL, saturating at all-ones.
- Victory: if the kill hits the last alive enemy (alive count was 1), vitoria=1 in the same cycle as the pulse.
- Ship hit: nave_atingida=1 and vidas_jogador decrements. When it reaches 0, fim_jogo=1 in the same cycle. The counter never wraps below 0.
- Simultaneous kill and ship hit in one pass: both take effect. If this produces both vitoria and fim_jogo, fim_jogo wins and vitoria stays 0.
- pausa rising mid-pass does not abort; the pass completes.
- reset asserted mid-pass: immediate abort to reset values, no pulses.

Optional Feature:
- Macro: COLISAO_NAVE_EN.
- Defined: NAVE state performs the enemy-ball-vs-ship test described above.
- Undefined: NAVE state is still traversed, so latency is unchanged. nave_atingida is tied 0, vidas_jogador is held at 3, and fim_jogo never sets.

Decomposition:
- Package colisao_pkg: FSM state enum, LIVES_INIT=3, COORD_W=10, EXT_W=11.
- Sub-module caixa_sobrepoe: combinational ball-box vs rectangle overlap with saturation. Instantiated once and muxed between SCAN and NAVE.

Test Plan:
- Ball (55,105,r5), enemy 2 at (50,100) size 20x10 alive, others far -> acerto_inimigo=0b0000000100 and bateu=1 at tick+13; pontuacao=10.
- Ball overlaps alive enemies 3 and 4 -> only bit 3 pulses; score +10 once.
- Ball overlaps a dead enemy (vidas bit 0) -> no pulses, score unchanged.
- Ball x=3, r=5 near enemy at x=0 -> saturated low edge detects hit; no wrap false miss with ball x=1020.
- Enemy ball on ship for 3 passes -> vidas_jogador 3->2->1->0, fim_jogo=1; a 4th frame_tick is ignored (busy stays 0).
- Single alive enemy killed -> vitoria=1; frame_tick during busy or with pausa=1 -> no pass; reset mid-SCAN -> all outputs return to reset values.

Source files
------------

// File: rtl/colisao_pkg.sv
// colisao_pkg: shared widths, lives count and FSM states for the collision/score block
package colisao_pkg;
  localparam int LIVES_INIT = 3;
  localparam int COORD_W = 10;
  localparam int EXT_W = 11;
  typedef enum logic [2:0] {IDLE, SNAP, SCAN, NAVE, UPDATE} estado_t;
endpackage

// File: rtl/caixa_sobrepoe.sv
// caixa_sobrepoe: ball bounding box vs rectangle overlap, low ball edges saturated at 0
module caixa_sobrepoe
  import colisao_pkg::*;
(
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] br,
  input  logic [COORD_W-1:0] rx,
  input  logic [COORD_W-1:0] ry,
  input  logic [COORD_W-1:0] rw,
  input  logic [COORD_W-1:0] rh,
  output logic               hit
);
  logic [EXT_W-1:0] bx_lo, bx_hi, by_lo, by_hi, rx_hi, ry_hi;
  always_comb begin
    bx_lo = (bx >= br) ? EXT_W'(bx) - EXT_W'(br) : '0;
    by_lo = (by >= br) ? EXT_W'(by) - EXT_W'(br) : '0;
    bx_hi = EXT_W'(bx) + EXT_W'(br);
    by_hi = EXT_W'(by) + EXT_W'(br);
    rx_hi = EXT_W'(rx) + EXT_W'(rw);
    ry_hi = EXT_W'(ry) + EXT_W'(rh);
    hit = (bx_lo < rx_hi) && (bx_hi >= EXT_W'(rx)) && (by_lo < ry_hi) && (by_hi >= EXT_W'(ry));
  end
endmodule

// File: rtl/colisao_placar.sv
// colisao_placar: per-frame enemy scan, kill/ship-hit pulses, score and lives; COLISAO_NAVE_EN enables ship hits
module colisao_placar
  import colisao_pkg::*;
#(
  parameter int SIZE_ENEMY     = 10,
  parameter int SCORE_PER_KILL = 10,
  parameter int SCORE_W        = 16
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic                            frame_tick,
  input  logic                            pausa,
  input  logic                            reiniciarJogo,
  input  logic [COORD_W-1:0]              x_bola_aliada,
  input  logic [COORD_W-1:0]              y_bola_aliada,
  input  logic [COORD_W-1:0]              raio_bola_aliada,
  input  logic [COORD_W-1:0]              x_bola_inimiga,
  input  logic [COORD_W-1:0]              y_bola_inimiga,
  input  logic [COORD_W-1:0]              raio_bola_inimiga,
  input  logic [COORD_W-1:0]              x_nave,
  input  logic [COORD_W-1:0]              y_nave,
  input  logic [COORD_W-1:0]              largura_nave,
  input  logic [COORD_W-1:0]              altura_nave,
  input  logic [COORD_W*SIZE_ENEMY-1:0]   x_inimigo,
  input  logic [COORD_W*SIZE_ENEMY-1:0]   y_inimigo,
  input  logic [COORD_W-1:0]              largura_inimigo,
  input  logic [COORD_W-1:0]              altura_inimigo,
  input  logic [SIZE_ENEMY-1:0]           vidas_inimigo,
  output logic [SIZE_ENEMY-1:0]           acerto_inimigo,
  output logic                            bateu,
  output logic                            nave_atingida,
  output logic [1:0]                      vidas_jogador,
  output logic [SCORE_W-1:0]              pontuacao,
  output logic                            fim_jogo,
  output logic                            vitoria,
  output logic                            busy
);
  localparam int KW = (SIZE_ENEMY > 1) ? $clog2(SIZE_ENEMY) : 1;
  localparam int CW = $clog2(SIZE_ENEMY + 1);
  localparam logic [SCORE_W:0] INC = (SCORE_W+1)'(SCORE_PER_KILL);
  estado_t estado, prox;
  logic [KW-1:0] k, idx;
  logic [CW-1:0] n_vivos;
  logic achou, sobre, perde, atingida, fim_novo;
  logic [SCORE_W:0] soma;
  logic [COORD_W-1:0] xa, ya, ra, xe, ye, re, xn, yn, wn, hn, wi, hi;
  logic [COORD_W-1:0] xi [SIZE_ENEMY];
  logic [COORD_W-1:0] yi [SIZE_ENEMY];
  logic [SIZE_ENEMY-1:0] vivos;
  logic [COORD_W-1:0] bx, by, br, rx, ry, rw, rh;
  always_comb begin
    prox = estado;
    if (estado == IDLE && frame_tick && !pausa && !fim_jogo && !vitoria) prox = SNAP;
    else if (estado == SNAP) prox = SCAN;
    else if (estado == SCAN && k == KW'(SIZE_ENEMY - 1)) prox = NAVE;
    else if (estado == NAVE) prox = UPDATE;
    else if (estado == UPDATE) prox = IDLE;
  end
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) estado <= IDLE;
    else estado <= reiniciarJogo ? IDLE : prox;
  assign busy = (estado != IDLE);
  always_ff @(posedge CLOCK_50)
    if (estado == SNAP) begin
      {xa, ya, ra} <= {x_bola_aliada, y_bola_aliada, raio_bola_aliada};
      {xe, ye, re} <= {x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga};
      {xn, yn, wn, hn} <= {x_nave, y_nave, largura_nave, altura_nave};
      {wi, hi} <= {largura_inimigo, altura_inimigo};
      vivos <= vidas_inimigo;
      for (int i = 0; i < SIZE_ENEMY; i++) begin
        xi[i] <= x_inimigo[i*COORD_W +: COORD_W];
        yi[i] <= y_inimigo[i*COORD_W +: COORD_W];
      end
    end
  // A single comparator is shared: ally ball vs enemy k while scanning, enemy ball vs ship in NAVE.
  always_comb begin
    bx = (estado == NAVE) ? xe : xa;
    by = (estado == NAVE) ? ye : ya;
    br = (estado == NAVE) ? re : ra;
    rx = (estado == NAVE) ? xn : xi[k];
    ry = (estado == NAVE) ? yn : yi[k];
    rw = (estado == NAVE) ? wn : wi;
    rh = (estado == NAVE) ? hn : hi;
  end
  caixa_sobrepoe u_caixa (
    .bx(bx), .by(by), .br(br), .rx(rx), .ry(ry), .rw(rw), .rh(rh), .hit(sobre)
  );
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      k <= '0;
      idx <= '0;
      achou <= 1'b0;
      n_vivos <= '0;
    end else if (estado == SNAP) begin
      k <= '0;
      idx <= '0;
      achou <= 1'b0;
      n_vivos <= '0;
    end else if (estado == SCAN) begin
      k <= k + KW'(1);
      if (vivos[k]) n_vivos <= n_vivos + CW'(1);
      if (vivos[k] && sobre && !achou) begin
        achou <= 1'b1;
        idx <= k;
      end
    end
`ifdef COLISAO_NAVE_EN
  logic nave_hit;
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) nave_hit <= 1'b0;
    else if (estado == SNAP) nave_hit <= 1'b0;
    else if (estado == NAVE) nave_hit <= sobre;
  always_comb begin
    atingida = nave_hit;
    perde = nave_hit && (vidas_jogador != 2'd0);
    fim_novo = fim_jogo || (perde && vidas_jogador == 2'd1);
  end
`else
  always_comb begin
    atingida = 1'b0;
    perde = 1'b0;
    fim_novo = fim_jogo;
  end
`endif
  assign soma = {1'b0, pontuacao} + INC;
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      acerto_inimigo <= '0;
      bateu <= 1'b0;
      nave_atingida <= 1'b0;
      vidas_jogador <= 2'(LIVES_INIT);
      pontuacao <= '0;
      fim_jogo <= 1'b0;
      vitoria <= 1'b0;
    end else begin
      acerto_inimigo <= '0;
      bateu <= 1'b0;
      nave_atingida <= 1'b0;
      if (reiniciarJogo) begin
        vidas_jogador <= 2'(LIVES_INIT);
        pontuacao <= '0;
        fim_jogo <= 1'b0;
        vitoria <= 1'b0;
      end else if (estado == UPDATE) begin
        acerto_inimigo <= achou ? SIZE_ENEMY'(1) << idx : '0;
        bateu <= achou;
        nave_atingida <= atingida;
        if (achou) pontuacao <= soma[SCORE_W] ? '1 : soma[SCORE_W-1:0];
        vidas_jogador <= vidas_jogador - {1'b0, perde};
        fim_jogo <= fim_novo;
        vitoria <= vitoria || (achou && n_vivos == CW'(1) && !fim_novo);
      end
    end
endmodule

// File: tb/tb_colisao_placar.sv
// tb_colisao_placar: scoreboard bench for colisao_placar with a frame-level reference model
module tb_colisao_placar;
  localparam int N = 10;
  localparam int LAT = N + 3;
  logic clk = 0, reset = 0, frame_tick = 0, pausa = 0, reiniciarJogo = 0;
  logic [9:0] xa = 500, ya = 50, ra = 3, xe = 100, ye = 300, re = 4;
  logic [9:0] xn = 300, yn = 200, wn = 30, hn = 20, wi = 20, hi = 10;
  logic [9:0] xi [N];
  logic [9:0] yi [N];
  logic [10*N-1:0] x_inimigo, y_inimigo;
  logic [N-1:0] vivos = '1;
  logic [N-1:0] acerto;
  logic bateu, nave_atingida, fim_jogo, vitoria, busy;
  logic [1:0] vidas_jogador;
  logic [15:0] pontuacao;
  typedef struct {
    logic [N-1:0] acerto;
    bit bateu, nave, fim, vit;
    int vidas, pont, tick;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  int m_vidas = 3, m_pont = 0;
  bit m_fim = 0, m_vit = 0;
  genvar g;
  for (g = 0; g < N; g++) begin : g_pack
    assign x_inimigo[g*10 +: 10] = xi[g];
    assign y_inimigo[g*10 +: 10] = yi[g];
  end
  colisao_placar #(.SIZE_ENEMY(N), .SCORE_PER_KILL(10), .SCORE_W(16)) dut (
    .CLOCK_50(clk), .reset(reset), .frame_tick(frame_tick), .pausa(pausa),
    .reiniciarJogo(reiniciarJogo),
    .x_bola_aliada(xa), .y_bola_aliada(ya), .raio_bola_aliada(ra),
    .x_bola_inimiga(xe), .y_bola_inimiga(ye), .raio_bola_inimiga(re),
    .x_nave(xn), .y_nave(yn), .largura_nave(wn), .altura_nave(hn),
    .x_inimigo(x_inimigo), .y_inimigo(y_inimigo),
    .largura_inimigo(wi), .altura_inimigo(hi), .vidas_inimigo(vivos),
    .acerto_inimigo(acerto), .bateu(bateu), .nave_atingida(nave_atingida),
    .vidas_jogador(vidas_jogador), .pontuacao(pontuacao), .fim_jogo(fim_jogo),
    .vitoria(vitoria), .busy(busy)
  );
  always #10 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end
  task automatic chk(input string nm, input longint a, input longint e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, a, e);
    end
  endtask
  // Ball box [c-r, c+r] (low edge clipped at 0) against rectangle [x, x+w), plain integers.
  function automatic bit ovl(int bx, int by, int br, int rx, int ry, int rw, int rh);
    int lx = (bx - br < 0) ? 0 : bx - br;
    int ly = (by - br < 0) ? 0 : by - br;
    return (lx < rx + rw) && (bx + br >= rx) && (ly < ry + rh) && (by + br >= ry);
  endfunction
  task automatic model_pass(output exp_t e);
    int hit = -1, alive = 0;
    bit nv = 0;
    for (int i = 0; i < N; i++) begin
      if (vivos[i]) alive++;
      if (vivos[i] && hit < 0 && ovl(xa, ya, ra, xi[i], yi[i], wi, hi)) hit = i;
    end
`ifdef COLISAO_NAVE_EN
    nv = ovl(xe, ye, re, xn, yn, wn, hn);
`endif
    e.acerto = '0;
    if (hit >= 0) begin
      e.acerto[hit] = 1'b1;
      m_pont = (m_pont + 10 > 65535) ? 65535 : m_pont + 10;
    end
    if (nv && m_vidas > 0) begin
      m_vidas--;
      if (m_vidas == 0) m_fim = 1;
    end
    if (hit >= 0 && alive == 1 && !m_fim) m_vit = 1;
    e.bateu = (hit >= 0);
    e.nave = nv;
    e.vidas = m_vidas;
    e.pont = m_pont;
    e.fim = m_fim;
    e.vit = m_vit;
  endtask
  initial begin : monitor
    bit prev_busy = 0, chk_zero = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_busy = 0;
        chk_zero = 0;
      end else begin
        if (chk_zero) chk("pulse_width", {acerto, bateu, nave_atingida}, 0);
        chk_zero = 0;
        if (prev_busy && !busy) begin
          if (q.size() == 0) chk("unexpected_pass", 1, 0);
          else begin
            e = q.pop_front();
            chk("latency", cyc - e.tick, LAT);
            chk("acerto", acerto, e.acerto);
            chk("bateu", bateu, e.bateu);
            chk("nave_atingida", nave_atingida, e.nave);
            chk("vidas", vidas_jogador, e.vidas);
            chk("pontuacao", pontuacao, e.pont);
            chk("fim_jogo", fim_jogo, e.fim);
            chk("vitoria", vitoria, e.vit);
            chk_zero = 1;
          end
        end
        prev_busy = busy;
      end
    end
  end
  task automatic tick(output bit acc);
    exp_t e;
    acc = !pausa && !m_fim && !m_vit;
    @(negedge clk);
    frame_tick = 1;
    if (acc) begin
      model_pass(e);
      e.tick = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    frame_tick = 0;
    chk(acc ? "busy_set" : "tick_dropped", busy, acc);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("pass_timeout", busy, 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic pass();
    bit acc;
    tick(acc);
    if (acc) wait_idle();
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_pulses"}, {acerto, bateu, nave_atingida}, 0);
    chk({nm, "_vidas"}, vidas_jogador, 3);
    chk({nm, "_pont"}, pontuacao, 0);
    chk({nm, "_fim_vit"}, {fim_jogo, vitoria}, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask
  task automatic restart();
    @(negedge clk);
    reiniciarJogo = 1;
    @(negedge clk);
    reiniciarJogo = 0;
    {m_vidas, m_pont, m_fim, m_vit} = {32'd3, 32'd0, 2'b00};
    chk_reset("restart");
  endtask
  task automatic far();
    for (int i = 0; i < N; i++) begin
      xi[i] = 10'(600 + 30 * i);
      yi[i] = 400;
    end
    vivos = '1;
    {xa, ya, ra} = {10'd500, 10'd50, 10'd3};
    {xe, ye, re} = {10'd100, 10'd300, 10'd4};
  endtask
  initial begin
    bit acc;
    int j;
    far();
    repeat (3) @(negedge clk);
    chk_reset("por");
    reset = 1;
    @(negedge clk);
    xi[2] = 50; yi[2] = 100; {xa, ya, ra} = {10'd55, 10'd105, 10'd5};
    pass();
    far();
    xi[3] = 50; yi[3] = 100; xi[4] = 45; yi[4] = 95; {xa, ya, ra} = {10'd55, 10'd105, 10'd5};
    pass();
    far();
    xi[0] = 50; yi[0] = 100; vivos[0] = 0; {xa, ya, ra} = {10'd55, 10'd105, 10'd5};
    pass();
    far();
    xi[1] = 0; yi[1] = 100; {xa, ya, ra} = {10'd3, 10'd105, 10'd5};
    pass();
    xa = 1020;
    pass();
    far();
    {xe, ye, re} = {10'd310, 10'd205, 10'd4};
    repeat (4) pass();
    restart();
    far();
    vivos = 10'b0000100000; xi[5] = 50; yi[5] = 100; {xa, ya, ra} = {10'd55, 10'd105, 10'd5};
    pass();
    pass();
    restart();
    pausa = 1;
    pass();
    pausa = 0;
    tick(acc);
    repeat (3) @(negedge clk);
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("busy_after_drop", busy, 0);
    tick(acc);
    repeat (3) @(negedge clk);
    pausa = 1;
    wait_idle();
    pausa = 0;
    for (int n = 0; n < 120; n++) begin
      for (int i = 0; i < N; i++) begin
        xi[i] = 10'($urandom_range(0, 1000));
        yi[i] = 10'($urandom_range(0, 470));
      end
      wi = 10'($urandom_range(4, 40));
      hi = 10'($urandom_range(4, 40));
      vivos = N'($urandom);
      if ($urandom_range(0, 9) == 0) vivos = N'(1) << $urandom_range(0, N - 1);
      j = $urandom_range(0, N - 1);
      ra = 10'($urandom_range(0, 12));
      if ($urandom_range(0, 1) == 1) begin
        xa = 10'(xi[j] + $urandom_range(0, 30));
        ya = 10'(yi[j] + $urandom_range(0, 30));
      end else begin
        xa = 10'($urandom_range(0, 1023));
        ya = 10'($urandom_range(0, 1023));
      end
      {xn, yn} = {10'($urandom_range(0, 900)), 10'($urandom_range(0, 450))};
      {wn, hn} = {10'($urandom_range(8, 40)), 10'($urandom_range(8, 30))};
      re = 10'($urandom_range(0, 10));
      if ($urandom_range(0, 3) == 0) {xe, ye} = {10'(xn + $urandom_range(0, 20)), 10'(yn + $urandom_range(0, 20))};
      else {xe, ye} = {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))};
      pausa = ($urandom_range(0, 9) == 0);
      pass();
      pausa = 0;
      if (m_fim || m_vit) begin
        pass();
        restart();
      end
    end
    far();
    xi[7] = 50; yi[7] = 100; {xa, ya, ra} = {10'd55, 10'd105, 10'd5};
    pass();
    @(negedge clk);
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    repeat (4) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk_reset("reset_mid_scan");
    {m_vidas, m_pont, m_fim, m_vit} = {32'd3, 32'd0, 2'b00};
    @(negedge clk);
    reset = 1;
    repeat (20) @(negedge clk);
    chk_reset("after_abort");
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
